// File: rtl/top_corr_engine.sv
// top_corr_engine: windowed correlation score engine.
//
// Accumulates Sf, Sg and Sfg over WIN qualified sample pairs, then computes
// the signed score WIN*Sfg - Sf*Sg in two pipelined steps (MUL, SUB).
// A one-cycle done pulse announces result and the tag of the window that
// produced it.
//
// Optional feature: define BEST_TRACK_EN to add a best-score tracker
// (bestscore/bestplace ports, cleared by clrbest). Without the macro the
// tracker and its ports are absent and clrbest is ignored.

module top_corr_engine #(
    parameter  int DW  = 3,
    parameter  int WIN = 16,
    parameter  int PW  = 6,
    localparam int LW  = $clog2(WIN + 1),
    localparam int SW  = 2*DW + 2*LW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startsig,
    input  logic [PW-1:0]        startplace,
    input  logic                 valid,
    input  logic [DW-1:0]        fdata,
    input  logic [DW-1:0]        gdata,
    input  logic                 clrbest,
    output logic                 busy,
    output logic                 done,
    output logic signed [SW-1:0] result,
    output logic [PW-1:0]        place,
    output logic                 overrun
`ifdef BEST_TRACK_EN
    ,
    output logic signed [SW-1:0] bestscore,
    output logic [PW-1:0]        bestplace
`endif
);

    // Accumulator and product widths sized so nothing can overflow.
    localparam int AW  = DW + LW;          // Sf, Sg
    localparam int QW  = 2*DW + LW;        // Sfg
    localparam int PRW = 2*DW + 2*LW;      // WIN*Sfg and Sf*Sg

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_MUL,
        S_SUB
    } state_t;

    state_t               state_q,   state_d;
    logic [LW-1:0]        count_q,   count_d;
    logic [AW-1:0]        sf_q,      sf_d;
    logic [AW-1:0]        sg_q,      sg_d;
    logic [QW-1:0]        sfg_q,     sfg_d;
    logic [PW-1:0]        tag_q,     tag_d;
    logic [PRW-1:0]       prod_a_q,  prod_a_d;
    logic [PRW-1:0]       prod_b_q,  prod_b_d;
    logic signed [SW-1:0] result_q,  result_d;
    logic [PW-1:0]        place_q,   place_d;
    logic                 done_q,    done_d;
    logic                 overrun_q, overrun_d;
    logic                 open_win;

    // Next-state and datapath updates for the window FSM.
    always_comb begin
        // NOTE: every variable driven here gets its hold value first, so no
        // branch of the case can leave it unassigned and infer a latch.
        state_d   = state_q;
        count_d   = count_q;
        sf_d      = sf_q;
        sg_d      = sg_q;
        sfg_d     = sfg_q;
        tag_d     = tag_q;
        prod_a_d  = prod_a_q;
        prod_b_d  = prod_b_q;
        result_d  = result_q;
        place_d   = place_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        open_win  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The cycle carrying done is still IDLE; a start there is dropped.
                if (startsig && !done_q) begin
                    open_win = 1'b1;
                end
            end
            S_ACC: begin
                if (startsig) begin
                    // Abort and restart; a coincident sample is discarded.
                    open_win = 1'b1;
                end else if (valid) begin
                    sf_d    = sf_q  + AW'(fdata);
                    sg_d    = sg_q  + AW'(gdata);
                    sfg_d   = sfg_q + QW'(fdata) * QW'(gdata);
                    count_d = count_q + LW'(1);
                    if (count_q == LW'(WIN - 1)) begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                prod_a_d = PRW'(sfg_q) * PRW'(WIN);
                prod_b_d = PRW'(sf_q) * PRW'(sg_q);
                state_d  = S_SUB;
                if (valid) begin
                    overrun_d = 1'b1;
                end
            end
            S_SUB: begin
                result_d = SW'(prod_a_q) - SW'(prod_b_q);
                place_d  = tag_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
                if (valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (open_win) begin
            state_d = S_ACC;
            count_d = '0;
            sf_d    = '0;
            sg_d    = '0;
            sfg_d   = '0;
            tag_d   = startplace;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            sf_q      <= '0;
            sg_q      <= '0;
            sfg_q     <= '0;
            tag_q     <= '0;
            prod_a_q  <= '0;
            prod_b_q  <= '0;
            result_q  <= '0;
            place_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            count_q   <= count_d;
            sf_q      <= sf_d;
            sg_q      <= sg_d;
            sfg_q     <= sfg_d;
            tag_q     <= tag_d;
            prod_a_q  <= prod_a_d;
            prod_b_q  <= prod_b_d;
            result_q  <= result_d;
            place_q   <= place_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign result  = result_q;
    assign place   = place_q;
    assign overrun = overrun_q;

`ifdef BEST_TRACK_EN
    localparam logic signed [SW-1:0] BEST_MIN = {1'b1, {(SW-1){1'b0}}};

    logic signed [SW-1:0] best_score_q, best_score_d, best_base;
    logic [PW-1:0]        best_place_q, best_place_d;

    // Best tracker: clear first, then let a finishing window compete.
    always_comb begin
        best_base    = clrbest ? BEST_MIN : best_score_q;
        best_score_d = best_base;
        best_place_d = clrbest ? '0 : best_place_q;
        if ((state_q == S_SUB) && (result_d > best_base)) begin
            best_score_d = result_d;
            best_place_d = tag_q;
        end
    end

    // Best tracker registers, updated on the edge that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_score_q <= BEST_MIN;
            best_place_q <= '0;
        end else begin
            best_score_q <= best_score_d;
            best_place_q <= best_place_d;
        end
    end

    assign bestscore = best_score_q;
    assign bestplace = best_place_q;
`else
    // clrbest has no function without the tracker.
    logic unused_clrbest;
    assign unused_clrbest = clrbest;
`endif

endmodule

// File: tb/tb_top_corr_engine.sv
// tb_top_corr_engine: directed and randomized windows checked against a
// sum-based reference score (WIN*sum(f*g) - sum(f)*sum(g)).
// Best-tracker checks are compiled in when BEST_TRACK_EN is defined.

module tb_top_corr_engine;

    localparam int DW  = 3;
    localparam int WIN = 16;
    localparam int PW  = 6;
    localparam int LW  = $clog2(WIN + 1);
    localparam int SW  = 2*DW + 2*LW + 2;
    localparam longint BEST_MIN = -(longint'(1) <<< (SW - 1));

    logic                 clk;
    logic                 rst;
    logic                 startsig;
    logic [PW-1:0]        startplace;
    logic                 valid;
    logic [DW-1:0]        fdata;
    logic [DW-1:0]        gdata;
    logic                 clrbest;
    logic                 busy;
    logic                 done;
    logic signed [SW-1:0] result;
    logic [PW-1:0]        place;
    logic                 overrun;
`ifdef BEST_TRACK_EN
    logic signed [SW-1:0] bestscore;
    logic [PW-1:0]        bestplace;
`endif

    int          checks;
    int          errors;
    int          fs [WIN];
    int          gs [WIN];
    longint      best_exp;
    logic [PW-1:0] bestp_exp;
    logic        ovr_exp;

    top_corr_engine #(.DW(DW), .WIN(WIN), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .startsig   (startsig),
        .startplace (startplace),
        .valid      (valid),
        .fdata      (fdata),
        .gdata      (gdata),
        .clrbest    (clrbest),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .place      (place),
        .overrun    (overrun)
`ifdef BEST_TRACK_EN
        ,
        .bestscore  (bestscore),
        .bestplace  (bestplace)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference score straight from the window definition.
    function automatic longint model_score();
        longint sf  = 0;
        longint sg  = 0;
        longint sfg = 0;
        for (int i = 0; i < WIN; i++) begin
            sf  += fs[i];
            sg  += gs[i];
            sfg += fs[i] * gs[i];
        end
        return longint'(WIN) * sfg - sf * sg;
    endfunction

    task automatic fill_const(input int f, input int g);
        for (int i = 0; i < WIN; i++) begin
            fs[i] = f;
            gs[i] = g;
        end
    endtask

    // One paired sample (c,d), one f-only sample a, one g-only sample b.
    task automatic fill_three(input int c, input int d, input int a, input int b);
        fill_const(0, 0);
        fs[0] = c;
        gs[0] = d;
        fs[1] = a;
        gs[2] = b;
    endtask

    task automatic fill_random();
        for (int i = 0; i < WIN; i++) begin
            fs[i] = int'($urandom_range(0, (1 << DW) - 1));
            gs[i] = int'($urandom_range(0, (1 << DW) - 1));
        end
    endtask

    task automatic model_reset();
        best_exp  = BEST_MIN;
        bestp_exp = '0;
        ovr_exp   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_bit({tag, "_busy"},    busy,    1'b0);
        check_bit({tag, "_done"},    done,    1'b0);
        check_val({tag, "_result"},  64'(result), 64'(0));
        check_val({tag, "_place"},   64'(place),  64'(0));
        check_bit({tag, "_overrun"}, overrun, 1'b0);
`ifdef BEST_TRACK_EN
        check_val({tag, "_bestscore"}, 64'(bestscore), 64'(BEST_MIN));
        check_val({tag, "_bestplace"}, 64'(bestplace), 64'(0));
`endif
    endtask

    task automatic start_win(input logic [PW-1:0] p);
        startsig   = 1'b1;
        startplace = p;
        step();
        startsig   = 1'b0;
        check_bit("busy_after_start", busy, 1'b1);
    endtask

    // Feed n samples; optional idle gaps with junk data between them.
    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                valid = 1'b0;
                fdata = DW'($urandom);
                gdata = DW'($urandom);
                step();
                check_bit("done_in_gap", done, 1'b0);
            end
            valid = 1'b1;
            fdata = DW'(fs[i]);
            gdata = DW'(gs[i]);
            step();
            valid = 1'b0;
            if (i < n - 1) begin
                check_bit("done_during_acc", done, 1'b0);
            end
        end
    endtask

    // Called one cycle after the edge that took the last sample.
    task automatic finish_win(input logic [PW-1:0] p, input bit ign_start,
                              input bit mul_valid, input bit clr);
        longint exp_score;
        exp_score = model_score();
        check_bit("done_lat1", done, 1'b0);
        check_bit("busy_lat1", busy, 1'b1);
        startsig   = ign_start;
        startplace = ~p;
        valid      = mul_valid;
        if (mul_valid) ovr_exp = 1'b1;
        step();
        valid   = 1'b0;
        clrbest = clr;
        check_bit("done_lat2", done, 1'b0);
        step();
        clrbest = 1'b0;
        check_bit("done_pulse", done, 1'b1);
        check_val("result", 64'(result), 64'(exp_score));
        check_val("place", 64'(place), 64'(p));
        check_bit("busy_at_done", busy, 1'b0);
        check_bit("overrun", overrun, ovr_exp);
        if (clr) begin
            best_exp  = BEST_MIN;
            bestp_exp = '0;
        end
        if (exp_score > best_exp) begin
            best_exp  = exp_score;
            bestp_exp = p;
        end
`ifdef BEST_TRACK_EN
        check_val("bestscore", 64'(bestscore), 64'(best_exp));
        check_val("bestplace", 64'(bestplace), 64'(bestp_exp));
`endif
        step();
        startsig = 1'b0;
        check_bit("done_single", done, 1'b0);
        check_bit("busy_after_done", busy, 1'b0);
        check_val("result_hold", 64'(result), 64'(exp_score));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        startsig   = 1'b0;
        startplace = '0;
        valid      = 1'b0;
        fdata      = '0;
        gdata      = '0;
        clrbest    = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // Samples in IDLE are ignored and do not set overrun.
        valid = 1'b1;
        fdata = 3'd7;
        gdata = 3'd7;
        repeat (3) step();
        valid = 1'b0;
        check_bit("idle_valid_busy", busy, 1'b0);
        check_bit("idle_valid_overrun", overrun, 1'b0);

        // Constant f=g=3: score 0 on place 5.
        fill_const(3, 3);
        start_win(6'd5);
        feed(WIN, 1'b0);
        finish_win(6'd5, 1'b0, 1'b0, 1'b0);

        // Eight 7/7 pairs then zeros: 3136; starts during MUL/SUB/done ignored.
        for (int i = 0; i < WIN; i++) begin
            fs[i] = (i < 8) ? 7 : 0;
            gs[i] = fs[i];
        end
        start_win(6'd6);
        feed(WIN, 1'b1);
        finish_win(6'd6, 1'b1, 1'b0, 1'b0);

        // Anti-phase 7/0 and 0/7: -3136, which does not beat the best.
        for (int i = 0; i < WIN; i++) begin
            fs[i] = (i % 2 == 0) ? 7 : 0;
            gs[i] = (i % 2 == 1) ? 7 : 0;
        end
        start_win(6'd7);
        feed(WIN, 1'b0);
        finish_win(6'd7, 1'b0, 1'b0, 1'b0);

        // Standalone clrbest.
        clrbest = 1'b1;
        step();
        clrbest   = 1'b0;
        best_exp  = BEST_MIN;
        bestp_exp = '0;
`ifdef BEST_TRACK_EN
        check_val("clrbest_score", 64'(bestscore), 64'(best_exp));
        check_val("clrbest_place", 64'(bestplace), 64'(bestp_exp));
`endif

        // Scores 100, 3136, 200 on places 1, 2, 3.
        fill_three(2, 4, 2, 3);
        start_win(6'd1);
        feed(WIN, 1'b1);
        finish_win(6'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) begin
            fs[i] = (i < 8) ? 7 : 0;
            gs[i] = fs[i];
        end
        start_win(6'd2);
        feed(WIN, 1'b0);
        finish_win(6'd2, 1'b0, 1'b0, 1'b0);
        fill_three(4, 4, 3, 4);
        start_win(6'd3);
        feed(WIN, 1'b1);
        finish_win(6'd3, 1'b0, 1'b0, 1'b0);

        // clrbest coincident with done: cleared, then takes this result (100).
        fill_three(2, 4, 2, 3);
        start_win(6'd10);
        feed(WIN, 1'b0);
        finish_win(6'd10, 1'b0, 1'b0, 1'b1);

        // Restart at sample 9 with a coincident (dropped) sample.
        fill_random();
        start_win(6'd4);
        feed(8, 1'b0);
        check_bit("pre_restart_done", done, 1'b0);
        startsig   = 1'b1;
        startplace = 6'd9;
        valid      = 1'b1;
        fdata      = 3'd7;
        gdata      = 3'd7;
        step();
        startsig = 1'b0;
        valid    = 1'b0;
        check_bit("restart_busy", busy, 1'b1);
        check_bit("restart_no_done", done, 1'b0);
        fill_random();
        feed(WIN, 1'b1);
        finish_win(6'd9, 1'b0, 1'b0, 1'b0);

        // Sample during MUL sets overrun, which stays set across windows.
        fill_random();
        start_win(6'd11);
        feed(WIN, 1'b0);
        finish_win(6'd11, 1'b0, 1'b1, 1'b0);
        fill_random();
        start_win(6'd12);
        feed(WIN, 1'b1);
        finish_win(6'd12, 1'b0, 1'b0, 1'b0);

        // Synchronous-time reset returns everything to reset values.
        rst = 1'b1;
        step();
        model_reset();
        check_reset_vals("rst_after_overrun");
        rst = 1'b0;
        step();

        // Asynchronous reset mid-window: window is discarded, no done.
        fill_random();
        start_win(6'd13);
        feed(5, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check_bit("post_rst_no_done", done, 1'b0);
        end
        check_bit("post_rst_idle", busy, 1'b0);

        // Randomized windows with random tags and gaps.
        for (int k = 0; k < 8; k++) begin
            logic [PW-1:0] p;
            p = PW'($urandom);
            fill_random();
            start_win(p);
            feed(WIN, 1'b1);
            finish_win(p, k[0], 1'b0, (k == 5));
        end

        // Extreme all-sevens window: score 0.
        fill_const(7, 7);
        start_win(6'd63);
        feed(WIN, 1'b0);
        finish_win(6'd63, 1'b0, 1'b0, 1'b0);

`ifndef BEST_TRACK_EN
        $display("model best score %0d at tag %0d", best_exp, bestp_exp);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/top_corr_engine.md
TOP_CORR_ENGINE -- requirements
Module: top_corr_engine

Interface
REQ-001 SHALL have parameter DW, default 3: width of unsigned f and g samples.
REQ-002 SHALL have parameter WIN, default 16: samples per window, legal range 2..1024.
REQ-003 SHALL have parameter PW, default 6: width of the place tag.
REQ-004 SHALL define LW = clog2(WIN+1) and SW = 2*DW+2*LW+2: width of the signed score.
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 startsig  in  1  one-cycle pulse that opens a window for the tag on startplace.
REQ-008 startplace  in  PW  tag of the candidate window, captured on startsig.
REQ-009 valid  in  1  sample strobe qualifying fdata and gdata.
REQ-010 fdata, gdata  in  DW each  unsigned sample pair.
REQ-011 clrbest  in  1  clears the best-score tracker.
REQ-012 busy  out  1  high from the startsig cycle until the done pulse.
REQ-013 done  out  1  one-cycle pulse when result and place are valid.
REQ-014 result  out  SW  signed score WIN*Sfg - Sf*Sg.
REQ-015 place  out  PW  tag of the window that produced result.
REQ-016 overrun  out  1  sticky flag: valid seen while busy was high in CALC.
REQ-017 bestscore  out  SW  largest result since reset or clrbest (only with BEST_TRACK_EN).
REQ-018 bestplace  out  PW  tag belonging to bestscore (only with BEST_TRACK_EN).

Function
REQ-019 FSM states SHALL be IDLE, ACC, MUL, SUB, with done asserted in the cycle SUB completes.
REQ-020 IDLE + startsig SHALL clear accumulators Sf, Sg, Sfg and count, latch startplace, and go to ACC.
REQ-021 In ACC, each valid SHALL add fdata to Sf, gdata to Sg and fdata*gdata to Sfg, and increment count.
REQ-022 Accumulators SHALL be unsigned, with widths DW+LW (Sf, Sg) and 2*DW+LW (Sfg); they never overflow.
REQ-023 When the WIN-th valid is accepted, the next state SHALL be MUL; no further samples are taken.
REQ-024 MUL SHALL register the products WIN*Sfg and Sf*Sg; SUB SHALL register their signed difference into result.
REQ-025 Latency SHALL be 2 cycles: done is high exactly 2 cycles after the clock edge accepting the WIN-th sample.
REQ-026 In the done cycle the state SHALL return to IDLE; result and place hold until the next done.
REQ-027 startsig in ACC SHALL abort the window, restart with the new startplace and count 0, and produce no done.
REQ-028 startsig in MUL/SUB SHALL be ignored; startsig in the done cycle SHALL be ignored.
REQ-029 valid in IDLE SHALL be ignored; valid in MUL or SUB SHALL set overrun, which clears only on reset.
REQ-030 A valid coinciding with a restarting startsig in ACC SHALL be dropped.
REQ-031 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-032 rst SHALL force IDLE and clear count, Sf, Sg, Sfg, result, place, done, overrun and busy to 0.
REQ-033 rst SHALL set bestscore to the most negative SW value and bestplace to 0.
REQ-034 rst asserted mid-window SHALL discard the window with no done.

Configuration
REQ-035 Macro BEST_TRACK_EN defined: on each done, if result > bestscore (signed compare), bestscore/bestplace SHALL update on the same edge that raises done.
REQ-036 With BEST_TRACK_EN defined, clrbest SHALL reload the REQ-033 values; clrbest coincident with done SHALL clear first and then update with that result.
REQ-037 Macro BEST_TRACK_EN undefined: bestscore, bestplace and the compare logic SHALL be absent, and clrbest SHALL be unused.

Verification
REQ-038 WIN=16, startplace=5, 16 samples f=g=3 -> done 2 cycles after the last sample, result=0, place=5.
REQ-039 WIN=16, f=7,g=7 for 8 samples then f=0,g=0 for 8 -> result=16*392-56*56=3136.
REQ-040 WIN=16, f alternating 7/0 and g alternating 0/7 -> result=0-56*56=-3136 (signed), bestscore unchanged after clrbest.
REQ-041 Restart at sample 9 with startplace=9, then 16 samples -> exactly one done with place=9.
REQ-042 valid pulsed in the MUL cycle -> overrun=1 and held; rst -> overrun=0 and all outputs at reset values.
REQ-043 BEST_TRACK_EN windows scoring 100, 3136, 200 on places 1, 2, 3 -> bestscore=3136, bestplace=2.
